// File: rtl/player_bullet.sv
// player_bullet: spawns a single player bullet on a shoot press, moves it
// up one step per frame, and retires it on a hit or at the top edge.
//
// Ports
//   frame_clk     in   1   frame-rate clock, all state updates on posedge
//   Reset         in   1   asynchronous active-high reset
//   shoot_bullet  in   1   fire key level, only its rising edge fires
//   player_X      in  10   player X, sampled only at spawn
//   hit           in   1   active bullet struck a target this frame
//   bullet_X      out 10   bullet X (constant while flying)
//   bullet_Y      out 10   bullet Y
//   bullet_active out  1   bullet on screen (draw and collide)
//   fired         out  1   one-frame pulse on spawn
module player_bullet #(
   parameter logic [9:0] BULLET_Y_START  = 10'd440,
   parameter logic [9:0] BULLET_Y_MIN    = 10'd8,
   parameter logic [9:0] BULLET_Y_STEP   = 10'd4,
   parameter logic [9:0] BULLET_X_OFFSET = 10'd0,
   parameter logic [7:0] COOLDOWN_FRAMES = 8'd15
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       shoot_bullet,
   input  logic [9:0] player_X,
   input  logic       hit,
   output logic [9:0] bullet_X,
   output logic [9:0] bullet_Y,
   output logic       bullet_active,
   output logic       fired
);

   typedef enum logic [1:0] {
      IDLE,
      FLYING,
      COOLDOWN
   } state_t;

   // Retire threshold widened by one bit so MIN+STEP cannot wrap.
   localparam logic [10:0] RETIRE_LIM =
      {1'b0, BULLET_Y_MIN} + {1'b0, BULLET_Y_STEP};

   state_t     state_q, state_d;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       active_q, active_d;
   logic       fired_q, fired_d;
   logic       prev_q;
   logic [7:0] cd_q, cd_d;

   logic fire_req;
   logic at_top;

   // A held key fires once; prev tracks the key every frame in every state.
   assign fire_req = shoot_bullet & ~prev_q;
   assign at_top   = ({1'b0, y_q} < RETIRE_LIM);

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      active_d = active_q;
      fired_d  = 1'b0;
      cd_d     = cd_q;
      unique case (state_q)
         IDLE: begin
            active_d = 1'b0;
            if (fire_req) begin
               state_d  = FLYING;
               x_d      = player_X + BULLET_X_OFFSET;
               y_d      = BULLET_Y_START;
               active_d = 1'b1;
               fired_d  = 1'b1;
            end
         end
         FLYING: begin
            // Hit wins over the top edge; both give one retire and Y is held.
            if (hit || at_top) begin
               state_d  = COOLDOWN;
               active_d = 1'b0;
               cd_d     = COOLDOWN_FRAMES;
            end else begin
               y_d = y_q - BULLET_Y_STEP;
            end
         end
         COOLDOWN: begin
            active_d = 1'b0;
            if (cd_q == 8'd0) begin
               state_d = IDLE;
            end else begin
               cd_d = cd_q - 8'd1;
            end
         end
         default: begin
            state_d  = IDLE;
            active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         x_q      <= 10'd0;
         y_q      <= BULLET_Y_START;
         active_q <= 1'b0;
         fired_q  <= 1'b0;
         prev_q   <= 1'b0;
         cd_q     <= 8'd0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         active_q <= active_d;
         fired_q  <= fired_d;
         prev_q   <= shoot_bullet;
         cd_q     <= cd_d;
      end
   end

   assign bullet_X      = x_q;
   assign bullet_Y      = y_q;
   assign bullet_active = active_q;
   assign fired         = fired_q;

endmodule

// File: tb/tb_player_bullet.sv
// tb_player_bullet: directed scenarios plus a randomized run against a
// frame-level behavioural model of the player bullet.
module tb_player_bullet;

   localparam int Y_START = 440;
   localparam int Y_MIN   = 8;
   localparam int Y_STEP  = 4;
   localparam int CD      = 15;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic       shoot;
   logic [9:0] player_X;
   logic       hit;
   logic [9:0] bx, by;
   logic       act, fired;

   logic       shoot2;
   logic [9:0] px2;
   logic       hit2;
   logic [9:0] bx2, by2;
   logic       act2, fired2;

   int n_cmp  = 0;
   int n_fail = 0;

   // model state
   logic       m_active;
   logic       m_fired;
   logic       m_prev;
   logic [9:0] m_x;
   logic [9:0] m_y;
   int         m_cool;

   player_bullet dut (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .shoot_bullet  (shoot),
      .player_X      (player_X),
      .hit           (hit),
      .bullet_X      (bx),
      .bullet_Y      (by),
      .bullet_active (act),
      .fired         (fired)
   );

   player_bullet #(
      .BULLET_X_OFFSET (10'd4),
      .COOLDOWN_FRAMES (8'd0)
   ) dut2 (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .shoot_bullet  (shoot2),
      .player_X      (px2),
      .hit           (hit2),
      .bullet_X      (bx2),
      .bullet_Y      (by2),
      .bullet_active (act2),
      .fired         (fired2)
   );

   always #5 frame_clk = ~frame_clk;

   // One frame of the game rules: a retire blocks new shots for
   // COOLDOWN+1 frames, presses during that time are dropped.
   function automatic void model_step();
      logic req;
      req     = shoot & ~m_prev;
      m_prev  = shoot;
      m_fired = 1'b0;
      if (m_active) begin
         if (hit || int'(m_y) < Y_MIN + Y_STEP) begin
            m_active = 1'b0;
            m_cool   = CD + 1;
         end else begin
            m_y = m_y - 10'(Y_STEP);
         end
      end else if (m_cool > 0) begin
         m_cool = m_cool - 1;
      end else if (req) begin
         m_active = 1'b1;
         m_fired  = 1'b1;
         m_x      = player_X;
         m_y      = 10'(Y_START);
      end
   endfunction

   function automatic void model_reset();
      m_active = 1'b0;
      m_fired  = 1'b0;
      m_prev   = 1'b0;
      m_x      = 10'd0;
      m_y      = 10'(Y_START);
      m_cool   = 0;
   endfunction

   task automatic tick();
      @(posedge frame_clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      shoot    = 1'b0;
      hit      = 1'b0;
      player_X = 10'd0;
      shoot2   = 1'b0;
      hit2     = 1'b0;
      px2      = 10'd0;
      Reset    = 1'b1;
      model_reset();
      @(negedge frame_clk);
      @(negedge frame_clk);
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (act !== 1'b0 || fired !== 1'b0 || by !== 10'd440 || bx !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_vals: act=%b fired=%b X=%0d Y=%0d, need 0 0 0 440",
                  act, fired, bx, by);
      end
      player_X = 10'd100;
      shoot    = 1'b1;
      tick();
      n_cmp++;
      if (fired !== 1'b1 || act !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_spawn: fired=%b act=%b, need 1 1", fired, act);
      end
      // async reset mid-flight, no clock edge before the check
      #2;
      Reset = 1'b1;
      model_reset();
      #1;
      n_cmp++;
      if (act !== 1'b0 || fired !== 1'b0 || by !== 10'd440) begin
         n_fail++;
         $display("FAIL reset_async: act=%b fired=%b Y=%0d, need 0 0 440",
                  act, fired, by);
      end
      shoot = 1'b0;
      @(negedge frame_clk);
      Reset = 1'b0;
      tick();
      shoot = 1'b1;
      tick();
      n_cmp++;
      if (fired !== 1'b1 || act !== 1'b1 || bx !== 10'd100) begin
         n_fail++;
         $display("FAIL reset_idle: fired=%b act=%b X=%0d, need 1 1 100",
                  fired, act, bx);
      end
   endtask

   task automatic test_spawn_flight();
      do_reset();
      player_X = 10'd320;
      tick();
      shoot = 1'b1;
      tick();
      n_cmp++;
      if (fired !== 1'b1 || bx !== 10'd320 || by !== 10'd440 || act !== 1'b1) begin
         n_fail++;
         $display("FAIL spawn: fired=%b X=%0d Y=%0d act=%b, need 1 320 440 1",
                  fired, bx, by, act);
      end
      player_X = 10'd7;
      for (int k = 1; k <= 6; k++) begin
         tick();
         n_cmp++;
         if (fired !== 1'b0 || by !== 10'(440 - 4 * k) || bx !== 10'd320) begin
            n_fail++;
            $display("FAIL flight_%0d: fired=%b Y=%0d X=%0d, need 0 %0d 320",
                     k, fired, by, bx, 440 - 4 * k);
         end
      end
   endtask

   task automatic test_top_retire();
      do_reset();
      tick();
      shoot = 1'b1;
      tick();
      shoot = 1'b0;
      for (int k = 1; k <= 108; k++) tick();
      n_cmp++;
      if (by !== 10'd8 || act !== 1'b1) begin
         n_fail++;
         $display("FAIL top_y8: Y=%0d act=%b, need 8 1", by, act);
      end
      tick();
      n_cmp++;
      if (act !== 1'b0 || by !== 10'd8) begin
         n_fail++;
         $display("FAIL top_retire: act=%b Y=%0d, need 0 8", act, by);
      end
      for (int k = 1; k <= 15; k++) tick();
      // last cooldown frame: press must be dropped
      shoot = 1'b1;
      tick();
      n_cmp++;
      if (act !== 1'b0 || fired !== 1'b0) begin
         n_fail++;
         $display("FAIL cd_press: act=%b fired=%b, need 0 0", act, fired);
      end
      shoot = 1'b0;
      tick();
      shoot = 1'b1;
      tick();
      n_cmp++;
      if (act !== 1'b1 || fired !== 1'b1) begin
         n_fail++;
         $display("FAIL cd_repress: act=%b fired=%b, need 1 1", act, fired);
      end
   endtask

   task automatic test_hit();
      do_reset();
      tick();
      shoot = 1'b1;
      tick();
      shoot = 1'b0;
      for (int k = 1; k <= 35; k++) tick();
      n_cmp++;
      if (by !== 10'd300) begin
         n_fail++;
         $display("FAIL hit_pre: Y=%0d, need 300", by);
      end
      hit = 1'b1;
      tick();
      hit = 1'b0;
      n_cmp++;
      if (act !== 1'b0 || by !== 10'd300) begin
         n_fail++;
         $display("FAIL hit300: act=%b Y=%0d, need 0 300", act, by);
      end
      // exactly 16 cooldown frames, then a press on frame 17 spawns
      for (int k = 1; k <= 16; k++) begin
         hit = 1'b1;
         tick();
      end
      hit   = 1'b0;
      shoot = 1'b1;
      tick();
      n_cmp++;
      if (act !== 1'b1 || fired !== 1'b1 || by !== 10'd440) begin
         n_fail++;
         $display("FAIL cd_len: act=%b fired=%b Y=%0d, need 1 1 440",
                  act, fired, by);
      end
      shoot = 1'b0;
      for (int k = 1; k <= 108; k++) tick();
      hit = 1'b1;
      tick();
      hit = 1'b0;
      n_cmp++;
      if (act !== 1'b0 || by !== 10'd8 || fired !== 1'b0) begin
         n_fail++;
         $display("FAIL hit_top: act=%b Y=%0d fired=%b, need 0 8 0",
                  act, by, fired);
      end
      for (int k = 1; k <= 16; k++) tick();
      shoot = 1'b1;
      tick();
      n_cmp++;
      if (act !== 1'b1 || fired !== 1'b1) begin
         n_fail++;
         $display("FAIL hit_top_once: act=%b fired=%b, need 1 1", act, fired);
      end
   endtask

   task automatic test_held_key();
      int bad;
      do_reset();
      tick();
      shoot = 1'b1;
      tick();
      for (int k = 1; k <= 10; k++) tick();
      hit = 1'b1;
      tick();
      hit = 1'b0;
      bad = 0;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (act !== 1'b0 || fired !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL held_key: respawn frames=%0d, need 0", bad);
      end
      shoot = 1'b0;
      tick();
      shoot = 1'b1;
      tick();
      n_cmp++;
      if (act !== 1'b1 || fired !== 1'b1) begin
         n_fail++;
         $display("FAIL held_release: act=%b fired=%b, need 1 1", act, fired);
      end
   endtask

   task automatic test_edge_values();
      do_reset();
      px2 = 10'd1023;
      tick();
      shoot2 = 1'b1;
      tick();
      n_cmp++;
      if (bx2 !== 10'd3 || fired2 !== 1'b1 || act2 !== 1'b1) begin
         n_fail++;
         $display("FAIL x_wrap: X=%0d fired=%b act=%b, need 3 1 1",
                  bx2, fired2, act2);
      end
      shoot2 = 1'b0;
      tick();
      hit2 = 1'b1;
      tick();
      hit2 = 1'b0;
      n_cmp++;
      if (act2 !== 1'b0) begin
         n_fail++;
         $display("FAIL cd0_retire: act=%b, need 0", act2);
      end
      tick();
      shoot2 = 1'b1;
      px2    = 10'd50;
      tick();
      n_cmp++;
      if (act2 !== 1'b1 || fired2 !== 1'b1 || bx2 !== 10'd54 || by2 !== 10'd440) begin
         n_fail++;
         $display("FAIL cd0_idle: act=%b fired=%b X=%0d Y=%0d, need 1 1 54 440",
                  act2, fired2, bx2, by2);
      end
      shoot2 = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(7) == 0) shoot = ~shoot;
         hit      = ($urandom_range(63) == 0);
         player_X = 10'($urandom);
         tick();
         n_cmp++;
         if (act !== m_active) begin
            n_fail++;
            $display("FAIL rnd_active@%0d: got %b expected %b", i, act, m_active);
         end
         n_cmp++;
         if (fired !== m_fired) begin
            n_fail++;
            $display("FAIL rnd_fired@%0d: got %b expected %b", i, fired, m_fired);
         end
         n_cmp++;
         if (by !== m_y) begin
            n_fail++;
            $display("FAIL rnd_Y@%0d: got %0d expected %0d", i, by, m_y);
         end
         n_cmp++;
         if (bx !== m_x) begin
            n_fail++;
            $display("FAIL rnd_X@%0d: got %0d expected %0d", i, bx, m_x);
         end
      end
   endtask

   initial begin
      test_reset();
      test_spawn_flight();
      test_top_retire();
      test_hit();
      test_held_key();
      test_edge_values();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
